booth_mul_seq: RTL and testbench
================================

// Module: booth_mul_seq
// PURPOSE
//  Sequential radix-2 Booth signed multiplier for the ALU multiply path.
//  Each cycle it issues one add, subtract or no-op of the multiplicand
//  into the partial product, then shifts. The add/sub stage is the same
//  function as the ALU carry-lookahead adder, at WIDTH+1 bits.
//  Sits beside the ALU adder; the execute stage uses a start/done handshake.
// PARAMETERS
//  WIDTH  8  operand width in bits (two's complement); product is 2*WIDTH
// PORTS
//  clk           in   1        single clock; all state updates on rising edge
//  rst           in   1        asynchronous, active-high reset
//  start         in   1        request a multiply; sampled only when accepted
//  multiplicand  in   WIDTH    signed operand M
//  multiplier    in   WIDTH    signed operand Q
//  busy          out  1        high while iterating (state RUN)
//  done          out  1        one-cycle pulse: product is valid
//  product       out  2*WIDTH  signed M*Q; held until next accepted start
// BEHAVIOUR
//  - Reset (async, any time incl. mid-operation): state=IDLE, busy=0, done=0,
//    product=0, internal A/Q/Q_1/count=0. Partial result is discarded.
//  - States: IDLE -> RUN on start. RUN -> RUN while count<WIDTH-1.
//    RUN -> DONE when count==WIDTH-1. DONE -> IDLE unconditionally,
//    or DONE -> RUN if start is high (back-to-back).
//  - Accept: start high at an edge in IDLE or DONE latches M=multiplicand
//    (sign-extended to WIDTH+1), A=0 (WIDTH+1 b), Q=multiplier, Q_1=0, count=0.
//  - start in RUN is ignored; operand changes after acceptance have no effect.
//  - RUN iteration, per edge, on {Q[0],Q_1}:
//    00/11 -> no op; 01 -> A=A+M; 10 -> A=A-M.
//    Then arithmetic shift right {A,Q,Q_1} by 1 (A MSB replicated); count++.
//  - A and the adder are WIDTH+1 bits, so M=-2^(WIDTH-1) is exact.
//    Adder carry-out/overflow are not used.
//  - On the edge completing iteration WIDTH-1: product = {A[WIDTH-1:0],Q},
//    taken after that final shift. State becomes DONE.
//  - Latency: start accepted at edge k; busy=1 for edges k+1..k+WIDTH;
//    done=1 and product valid in cycle after edge k+WIDTH (WIDTH+1 cycles).
//  - busy and done are never high together. done is exactly one cycle wide.
//  - product changes only at the completion edge or on reset.
// STRUCTURE
//  - Package alu_pkg: typedef enum logic [1:0] {MUL_IDLE,MUL_RUN,MUL_DONE}
//    mul_state_t; localparam BOOTH_NOP/ADD/SUB encodings of {Q[0],Q_1}.
//  - Sub-module booth_addsub #(W=WIDTH+1): combinational a, b, mode
//    (0=add, 1=sub via ~b+1) -> sum. One instance, driven by the FSM.
//  - Count register is $clog2(WIDTH) bits; FSM and datapath in one always_ff
//    with async reset.
// TESTING
//  - 3*5: start pulse -> done 9 cycles later, product=16'h000F, busy 8 cycles
//  - (-3)*5 and 5*(-3) -> product=16'hFFF1 both
//  - (-128)*(-128) -> 16'h4000; (-128)*127 -> 16'hC080; 0*(-77) -> 16'h0000
//  - start held high through RUN with new operands -> ignored;
//    first result stands. Back-to-back start in DONE -> second result 9 cycles on.
//  - rst asserted at iteration 4 -> immediate busy=0, product=0, no done;
//    new start after release -> correct result
//  - Random: 1000 signed pairs checked against $signed(a)*$signed(b)
//    at every done pulse

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU-side definitions for the sequential Booth multiplier.
// Contents:
//   mul_state_t     - multiplier FSM states (idle, iterating, result valid)
//   BOOTH_NOP/ADD/SUB - encodings of the Booth pair {Q[0], Q_1}
package alu_pkg;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    // {Q[0], Q_1}: 01 marks the end of a run of ones (add M),
    // 10 marks the start of a run of ones (subtract M); 00/11 do nothing.
    localparam logic [1:0] BOOTH_NOP = 2'b00;
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_addsub.sv
// Combinational adder/subtractor used by the Booth multiplier datapath.
// Same function as the ALU carry-lookahead adder; carry-out is not exported.
// Ports:
//   a    in  W  first operand
//   b    in  W  second operand
//   mode in  1  0 = a + b, 1 = a - b (computed as a + ~b + 1)
//   sum  out W  result, modulo 2^W
module booth_addsub #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         mode,
    output logic [W-1:0] sum
);

    logic [W-1:0] b_eff_s;
    logic [W-1:0] cin_s;

    // Subtraction reuses the adder: invert b and inject a carry-in of one.
    always_comb begin
        b_eff_s = b;
        cin_s   = {W{1'b0}};
        if (mode) begin
            b_eff_s = ~b;
            cin_s   = {{(W-1){1'b0}}, 1'b1};
        end else begin
            b_eff_s = b;
            cin_s   = {W{1'b0}};
        end
    end

    assign sum = a + b_eff_s + cin_s;

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth signed multiplier (one Booth step per clock).
// Ports:
//   clk          in  1        rising-edge clock
//   rst          in  1        asynchronous, active-high reset
//   start        in  1        multiply request, accepted in IDLE or DONE
//   multiplicand in  WIDTH    signed operand M
//   multiplier   in  WIDTH    signed operand Q
//   busy         out 1        high while iterating
//   done         out 1        one-cycle pulse, product valid
//   product      out 2*WIDTH  signed M*Q, held until the next completion
module booth_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    mul_state_t           state_r;
    mul_state_t           next_state_s;
    logic                 accept_s;
    logic [WIDTH:0]       m_r;
    logic [WIDTH:0]       a_r;
    logic [WIDTH-1:0]     q_r;
    logic                 q_1_r;
    logic [CW-1:0]        count_r;
    logic [2*WIDTH-1:0]   product_r;
    logic                 busy_r;
    logic                 done_r;

    logic                 add_en_s;
    logic                 sub_s;
    logic [WIDTH:0]       sum_s;
    logic [WIDTH:0]       a_op_s;
    logic [WIDTH:0]       a_sh_s;
    logic [WIDTH-1:0]     q_sh_s;

    // Next-state logic; start is only honoured in IDLE or DONE.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            MUL_IDLE: begin
                if (start) begin
                    next_state_s = MUL_RUN;
                    accept_s     = 1'b1;
                end else begin
                    next_state_s = MUL_IDLE;
                end
            end
            MUL_RUN: begin
                if (count_r == LAST_COUNT) begin
                    next_state_s = MUL_DONE;
                end else begin
                    next_state_s = MUL_RUN;
                end
            end
            MUL_DONE: begin
                if (start) begin
                    next_state_s = MUL_RUN;
                    accept_s     = 1'b1;
                end else begin
                    next_state_s = MUL_IDLE;
                end
            end
            default: begin
                next_state_s = MUL_IDLE;
            end
        endcase
    end

    // Booth step selection from the current pair {Q[0], Q_1}.
    always_comb begin
        add_en_s = 1'b0;
        sub_s    = 1'b0;
        case ({q_r[0], q_1_r})
            BOOTH_ADD: begin
                add_en_s = 1'b1;
                sub_s    = 1'b0;
            end
            BOOTH_SUB: begin
                add_en_s = 1'b1;
                sub_s    = 1'b1;
            end
            default: begin
                add_en_s = 1'b0;
                sub_s    = 1'b0;
            end
        endcase
    end

    booth_addsub #(.W(WIDTH + 1)) u_addsub (
        .a    (a_r),
        .b    (m_r),
        .mode (sub_s),
        .sum  (sum_s)
    );

    // A is one bit wider than the operands, so subtracting M = -2^(WIDTH-1)
    // cannot overflow; the arithmetic shift replicates that extra sign bit.
    assign a_op_s = add_en_s ? sum_s : a_r;
    assign a_sh_s = {a_op_s[WIDTH], a_op_s[WIDTH:1]};
    assign q_sh_s = {a_op_s[0], q_r[WIDTH-1:1]};

    // FSM state, datapath registers and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= MUL_IDLE;
            m_r       <= {(WIDTH+1){1'b0}};
            a_r       <= {(WIDTH+1){1'b0}};
            q_r       <= {WIDTH{1'b0}};
            q_1_r     <= 1'b0;
            count_r   <= {CW{1'b0}};
            product_r <= {(2*WIDTH){1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == MUL_RUN);
            done_r  <= (next_state_s == MUL_DONE);
            if (accept_s) begin
                m_r     <= {multiplicand[WIDTH-1], multiplicand};
                a_r     <= {(WIDTH+1){1'b0}};
                q_r     <= multiplier;
                q_1_r   <= 1'b0;
                count_r <= {CW{1'b0}};
            end else if (state_r == MUL_RUN) begin
                a_r     <= a_sh_s;
                q_r     <= q_sh_s;
                q_1_r   <= q_r[0];
                count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                // The low 2*WIDTH bits of {A,Q} after the final shift hold M*Q.
                if (count_r == LAST_COUNT) begin
                    product_r <= {a_sh_s[WIDTH-1:0], q_sh_s};
                end else begin
                    product_r <= product_r;
                end
            end else begin
                a_r     <= a_r;
                q_r     <= q_r;
                q_1_r   <= q_1_r;
                count_r <= count_r;
            end
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq (WIDTH = 8).
module tb_booth_mul_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int n_checks;
    int n_pass;

    booth_mul_seq #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Count negedges after the accept edge until done; bounded.
    task automatic wait_done(input string tag, output int lat, output int busy_cnt);
        int overlap;
        lat      = 0;
        busy_cnt = 0;
        overlap  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (busy && done) overlap++;
            if (busy) busy_cnt++;
            if (done) break;
        end
        check_eq({tag, "_done_seen"}, {31'd0, done}, 32'd1);
        check_eq({tag, "_no_overlap"}, overlap, 32'd0);
    endtask

    // Launch one multiply from IDLE and check product and timing.
    task automatic run_mul(input string tag, input logic [7:0] m, input logic [7:0] q,
                           input logic [15:0] exp, input bit check_timing);
        int lat;
        int bc;
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        multiplicand = 8'h00;
        multiplier   = 8'h00;
        wait_done(tag, lat, bc);
        check_eq({tag, "_product"}, {16'd0, product}, {16'd0, exp});
        if (check_timing) begin
            check_eq({tag, "_latency"}, lat, 32'd9);
            check_eq({tag, "_busy_cycles"}, bc, 32'd8);
            @(negedge clk);
            check_eq({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
            check_eq({tag, "_hold"}, {16'd0, product}, {16'd0, exp});
        end
    endtask

    initial begin
        int lat;
        int bc;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [15:0] rexp;
        n_checks     = 0;
        n_pass       = 0;
        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = 8'h00;
        multiplier   = 8'h00;
        repeat (2) @(negedge clk);
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        check_eq("reset_done", {31'd0, done}, 32'd0);
        check_eq("reset_product", {16'd0, product}, 32'd0);
        rst = 1'b0;

        // Directed vectors
        run_mul("3x5", 8'd3, 8'd5, 16'h000F, 1'b1);
        run_mul("m3x5", 8'hFD, 8'd5, 16'hFFF1, 1'b1);
        run_mul("5xm3", 8'd5, 8'hFD, 16'hFFF1, 1'b0);
        run_mul("m128xm128", 8'h80, 8'h80, 16'h4000, 1'b0);
        run_mul("m128x127", 8'h80, 8'h7F, 16'hC080, 1'b1);
        run_mul("0xm77", 8'h00, 8'hB3, 16'h0000, 1'b0);
        run_mul("127x127", 8'h7F, 8'h7F, 16'h3F01, 1'b0);

        // start held high through RUN with changing operands is ignored
        @(negedge clk);
        multiplicand = 8'd3;
        multiplier   = 8'd5;
        start        = 1'b1;
        @(posedge clk);
        #1;
        multiplicand = 8'd7;
        multiplier   = 8'd9;
        wait_done("held", lat, bc);
        start = 1'b0;
        check_eq("held_product", {16'd0, product}, 32'h000F);
        check_eq("held_latency", lat, 32'd9);

        // Back-to-back: start while in DONE launches the next multiply
        @(negedge clk);
        check_eq("held_idle", {31'd0, busy}, 32'd0);
        multiplicand = 8'd6;
        multiplier   = 8'd7;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("b2b_first", lat, bc);
        check_eq("b2b_first_product", {16'd0, product}, 32'h002A);
        multiplicand = 8'hFD;
        multiplier   = 8'd5;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("b2b_second", lat, bc);
        check_eq("b2b_second_latency", lat, 32'd9);
        check_eq("b2b_second_product", {16'd0, product}, 32'h0000FFF1);

        // Reset in the middle of an operation discards it
        @(negedge clk);
        multiplicand = 8'd10;
        multiplier   = 8'd10;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_mid_done", {31'd0, done}, 32'd0);
        check_eq("rst_mid_product", {16'd0, product}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) bc++;
        end
        check_eq("rst_no_done", bc, 32'd0);
        run_mul("after_rst", 8'd10, 8'hF6, 16'hFF9C, 1'b1);

        // Random signed pairs against the bench's own product
        for (int i = 0; i < 1000; i++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rexp = 16'($signed(ra) * $signed(rb));
            run_mul("rand", ra, rb, rexp, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
